game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl.sv | 164 ++++++++++++++++
 tb/tb_game_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// Game/shot clock sequencer: debounced-free key edge detection, BCD game and shot
// clocks, quarter tracking and buzzer pulse generation.
module game_ctrl #(
  parameter logic [7:0] QTR_MIN  = 8'h10,
  parameter logic [7:0] SHOT_SEC = 8'h24,
  parameter int         NUM_QTR  = 4,
  parameter int         BUZZ_CYC = 50_000_000
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        tick_1hz,
  input  logic        start_key,
  input  logic        pause_key,
  input  logic        shot_rst_key,
  input  logic [15:0] score,
  output logic        en_score,
  output logic [15:0] game_time,
  output logic [7:0]  shot_time,
  output logic [2:0]  quarter,
  output logic [2:0]  state,
  output logic        buzzer
);

  // state     | meaning
  // IDLE      | waiting for the first start
  // RUN       | clocks count down on tick_1hz
  // PAUSE     | clocks held, waiting for start
  // SHOT_VIOL | shot clock expired, clocks held
  // QTR_END   | game clock expired, waiting for next quarter
  // OVER      | final quarter finished, held until reset
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    PAUSE     = 3'd2,
    SHOT_VIOL = 3'd3,
    QTR_END   = 3'd4,
    OVER      = 3'd5
  } state_t;

  localparam logic [2:0]  LAST_QTR  = 3'(NUM_QTR);
  localparam logic [31:0] BUZZ_LOAD = 32'(BUZZ_CYC);

  state_t      state_q, state_nxt;
  logic [15:0] game_q, game_nxt;
  logic [7:0]  shot_q, shot_nxt;
  logic [2:0]  qtr_q, qtr_nxt;
  logic        en_q;
  logic [31:0] buzz_cnt;
  logic [15:0] score_q;

  logic [2:0]  key_s1, key_s2, key_prev, key_edge;
  logic [1:0]  warm;
  logic        start_edge, pause_edge, shot_edge, score_chg, reload, buzz_entry;

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'h0) r = {v[7:4] - 4'h1, 4'h9};
    else                r = {v[7:4], v[3:0] - 4'h1};
    return r;
  endfunction

  function automatic logic [15:0] game_dec(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t != 16'h0000) begin
      if (t[7:0] == 8'h00) r = {bcd_dec(t[15:8]), 8'h59};
      else                 r = {t[15:8], bcd_dec(t[7:0])};
    end
    return r;
  endfunction

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      key_s1   <= 3'b000;
      key_s2   <= 3'b000;
      key_prev <= 3'b000;
      warm     <= 2'd0;
    end else begin
      key_s1   <= {shot_rst_key, pause_key, start_key};
      key_s2   <= key_s1;
      key_prev <= key_s2;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  // Edges are masked until the synchronizer has refilled, so a key held through reset is no press.
  assign key_edge   = (warm == 2'd3) ? (key_s2 & ~key_prev) : 3'b000;
  assign start_edge = key_edge[0];
  assign pause_edge = key_edge[1];
  assign shot_edge  = key_edge[2];
  assign score_chg  = (score != score_q);
  assign reload     = score_chg | shot_edge;

  always_comb begin
    state_nxt = state_q;
    game_nxt  = game_q;
    shot_nxt  = shot_q;
    qtr_nxt   = qtr_q;
    case (state_q)
      IDLE: if (start_edge) state_nxt = RUN;
      RUN: begin
        if (tick_1hz) begin
          game_nxt = game_dec(game_q);
          if (shot_q != 8'h00) shot_nxt = bcd_dec(shot_q);
        end
        if (reload) shot_nxt = SHOT_SEC;
        if (game_nxt == 16'h0000)  state_nxt = QTR_END;
        else if (shot_nxt == 8'h00) state_nxt = SHOT_VIOL;
        else if (pause_edge)        state_nxt = PAUSE;
      end
      PAUSE, SHOT_VIOL: begin
        if (reload) shot_nxt = SHOT_SEC;
        if (start_edge) begin
          shot_nxt  = SHOT_SEC;
          state_nxt = RUN;
        end
      end
      QTR_END: begin
        if (qtr_q == LAST_QTR) begin
          state_nxt = OVER;
        end else if (start_edge) begin
          qtr_nxt   = qtr_q + 3'd1;
          game_nxt  = {QTR_MIN, 8'h00};
          shot_nxt  = SHOT_SEC;
          state_nxt = RUN;
        end
      end
      OVER:    state_nxt = OVER;
      default: state_nxt = IDLE;
    endcase
  end

  assign buzz_entry = (state_nxt != state_q) &&
                      ((state_nxt == SHOT_VIOL) || (state_nxt == QTR_END) || (state_nxt == OVER));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      game_q   <= {QTR_MIN, 8'h00};
      shot_q   <= SHOT_SEC;
      qtr_q    <= 3'd1;
      en_q     <= 1'b0;
      buzz_cnt <= 32'd0;
      score_q  <= 16'h0000;
    end else begin
      state_q <= state_nxt;
      game_q  <= game_nxt;
      shot_q  <= shot_nxt;
      qtr_q   <= qtr_nxt;
      en_q    <= (state_nxt == RUN) || (state_nxt == PAUSE) || (state_nxt == SHOT_VIOL);
      score_q <= score;
      if (buzz_entry)               buzz_cnt <= BUZZ_LOAD;
      else if (buzz_cnt != 32'd0)   buzz_cnt <= buzz_cnt - 32'd1;
    end
  end

  assign state     = state_q;
  assign game_time = game_q;
  assign shot_time = shot_q;
  assign quarter   = qtr_q;
  assign en_score  = en_q;
  assign buzzer    = (buzz_cnt != 32'd0);

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenarios plus randomized play, checked every cycle
// against a seconds-based behavioural model.
module tb_game_ctrl;
  localparam logic [7:0] QMIN = 8'h01;
  localparam logic [7:0] SSEC = 8'h05;
  localparam int NQ   = 2;
  localparam int BZ   = 4;
  localparam int QSEC = 60;  // 01 minute
  localparam int SHOT = 5;   // 05 seconds

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b1;
  logic        tick_1hz = 1'b0;
  logic        start_key = 1'b0, pause_key = 1'b0, shot_rst_key = 1'b0;
  logic [15:0] score = 16'h0000;
  logic        en_score, buzzer;
  logic [15:0] game_time;
  logic [7:0]  shot_time;
  logic [2:0]  quarter, state;

  game_ctrl #(.QTR_MIN(QMIN), .SHOT_SEC(SSEC), .NUM_QTR(NQ), .BUZZ_CYC(BZ)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .tick_1hz(tick_1hz), .start_key(start_key),
    .pause_key(pause_key), .shot_rst_key(shot_rst_key), .score(score),
    .en_score(en_score), .game_time(game_time), .shot_time(shot_time),
    .quarter(quarter), .state(state), .buzzer(buzzer)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0, n_bad = 0;
  bit cmp_on = 1'b0;
  int k_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd8(input int x);
    return 8'(((x / 10) * 16) + (x % 10));
  endfunction

  function automatic logic [15:0] bcd_mmss(input int s);
    return {bcd8(s / 60), bcd8(s % 60)};
  endfunction

  // Model: times in plain seconds; state numbers are the published codes.
  int m_st = 0, m_q = 1, m_g = QSEC, m_sh = SHOT, m_bz = 0, m_n = 0, ns;
  bit m_en = 1'b0, chg;
  bit [2:0] h1 = 3'b0, h2 = 3'b0, h3 = 3'b0, ev;
  logic [15:0] m_sq = 16'h0000;

  initial forever begin
    @(posedge clk_in or negedge rst_n);
    if (!rst_n) begin
      m_st = 0; m_q = 1; m_g = QSEC; m_sh = SHOT; m_bz = 0; m_n = 0; m_en = 1'b0;
      h1 = 3'b0; h2 = 3'b0; h3 = 3'b0; m_sq = 16'h0000;
    end else begin
      if (m_n < 10) m_n++;
      // a key sampled high two edges ago, low three edges ago, acts now
      ev = (m_n >= 4) ? (h2 & ~h3) : 3'b000;
      h3 = h2; h2 = h1; h1 = {shot_rst_key, pause_key, start_key};
      chg = (score != m_sq);
      m_sq = score;
      ns = m_st;
      case (m_st)
        0: if (ev[0]) ns = 1;
        1: begin
          if (tick_1hz) begin
            if (m_g > 0) m_g--;
            if (m_sh > 0) m_sh--;
          end
          if (chg || ev[2]) m_sh = SHOT;
          if (m_g == 0) ns = 4;
          else if (m_sh == 0) ns = 3;
          else if (ev[1]) ns = 2;
        end
        2, 3: begin
          if (chg || ev[2]) m_sh = SHOT;
          if (ev[0]) begin m_sh = SHOT; ns = 1; end
        end
        4: begin
          if (m_q == NQ) ns = 5;
          else if (ev[0]) begin m_q++; m_g = QSEC; m_sh = SHOT; ns = 1; end
        end
        default: ;
      endcase
      if (ns != m_st && ns >= 3) m_bz = BZ;
      else if (m_bz > 0) m_bz--;
      m_en = (ns >= 1 && ns <= 3);
      m_st = ns;
    end
  end

  initial forever begin
    @(negedge clk_in);
    if (cmp_on) begin
      chk("cyc_state", state, m_st);
      chk("cyc_quarter", quarter, m_q);
      chk("cyc_game", game_time, bcd_mmss(m_g));
      chk("cyc_shot", shot_time, bcd8(m_sh));
      chk("cyc_en", en_score, m_en);
      chk("cyc_buzzer", buzzer, m_bz > 0);
    end
  end

  task automatic do_tick(input bit c);
    @(negedge clk_in);
    tick_1hz = 1'b1;
    if (c) score = score + 16'h0001;
    @(negedge clk_in);
    tick_1hz = 1'b0;
  endtask

  task automatic press_start();
    @(negedge clk_in);
    start_key = 1'b1;
    repeat (3) @(negedge clk_in);
    start_key = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic buzz_len(input string nm, input int exp);
    int c;
    c = buzzer ? 1 : 0;
    repeat (7) begin
      @(negedge clk_in);
      if (buzzer) c++;
    end
    chk(nm, c, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_en"}, en_score, 0);
    chk({tag, "_buzzer"}, buzzer, 0);
    chk({tag, "_quarter"}, quarter, 1);
    chk({tag, "_game"}, game_time, 16'h0100);
    chk({tag, "_shot"}, shot_time, 8'h05);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1 cmp_on = 1'b1;
    chk_reset_vals("rst0");
    #21 rst_n = 1'b1;
    repeat (5) @(negedge clk_in);

    // start latency: key high before edge 1 acts on edge 3
    @(negedge clk_in); start_key = 1'b1;
    @(negedge clk_in); chk("lat_e1", state, 0);
    @(negedge clk_in); chk("lat_e2", state, 0);
    @(negedge clk_in); chk("lat_e3", state, 1);
    start_key = 1'b0;
    repeat (2) @(negedge clk_in);

    // five ticks with no score change -> shot violation
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk_in);
      do_tick(1'b0);
    end
    chk("sv_state", state, 3);
    chk("sv_game", game_time, 16'h0055);
    chk("sv_shot", shot_time, 8'h00);
    chk("sv_en", en_score, 1);
    buzz_len("sv_buzz", 4);

    press_start();
    chk("resume_state", state, 1);
    chk("resume_shot", shot_time, 8'h05);
    do_tick(1'b0);
    chk("tick_shot", shot_time, 8'h04);
    do_tick(1'b1);
    chk("tickchg_shot", shot_time, 8'h05);
    chk("tickchg_game", game_time, 16'h0053);

    // run quarter 1 out with a score change every fourth tick
    k_cnt = 0;
    for (int i = 0; i < 120 && m_st != 4; i++) begin
      k_cnt++;
      do_tick(k_cnt % 4 == 0);
    end
    chk("q1end_state", state, 4);
    chk("q1end_game", game_time, 16'h0000);
    chk("q1end_en", en_score, 0);
    buzz_len("q1end_buzz", 4);
    press_start();
    chk("q2_state", state, 1);
    chk("q2_quarter", quarter, 2);
    chk("q2_game", game_time, 16'h0100);

    // simultaneous start and pause while running
    do_tick(1'b0);
    do_tick(1'b0);
    @(negedge clk_in); start_key = 1'b1; pause_key = 1'b1;
    repeat (3) @(negedge clk_in);
    start_key = 1'b0; pause_key = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("sp_state", state, 2);
    repeat (3) do_tick(1'b0);
    chk("pause_state", state, 2);
    chk("pause_game", game_time, 16'h0058);
    chk("pause_shot", shot_time, 8'h03);

    // randomized play, keeping enough game time left for the ending below
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_in);
      tick_1hz = (m_g > 20) && ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) score = 16'($urandom);
      if ($urandom_range(0, 9) == 0) start_key = ~start_key;
      if ($urandom_range(0, 9) == 0) pause_key = ~pause_key;
      if ($urandom_range(0, 11) == 0) shot_rst_key = ~shot_rst_key;
    end
    @(negedge clk_in);
    tick_1hz = 1'b0; start_key = 1'b0; pause_key = 1'b0; shot_rst_key = 1'b0;
    repeat (5) @(negedge clk_in);

    if (m_st == 2 || m_st == 3) press_start();
    for (int i = 0; i < 100 && m_st != 4; i++) do_tick(1'b1);
    chk("q2end_state", state, 4);
    chk("q2end_quarter", quarter, 2);
    @(negedge clk_in);
    chk("over_state", state, 5);
    buzz_len("over_buzz", 4);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      tick_1hz = ($urandom_range(0, 2) == 0);
      start_key = 1'($urandom);
      pause_key = 1'($urandom);
      shot_rst_key = 1'($urandom);
      score = 16'($urandom);
    end
    @(negedge clk_in);
    tick_1hz = 1'b0; start_key = 1'b0; pause_key = 1'b0; shot_rst_key = 1'b0;
    repeat (4) @(negedge clk_in);
    chk("over_hold_state", state, 5);
    chk("over_hold_game", game_time, 16'h0000);

    // reset mid-run with buzzer active, start held through release
    @(negedge clk_in); #2 rst_n = 1'b0;
    @(negedge clk_in); #2 rst_n = 1'b1;
    repeat (5) @(negedge clk_in);
    press_start();
    repeat (5) do_tick(1'b0);
    chk("e_sv_state", state, 3);
    start_key = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("e_run_state", state, 1);
    chk("e_run_buzz", buzzer, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("rst_mid");
    repeat (2) @(negedge clk_in);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk_in);
    chk("held_state", state, 0);
    chk("held_buzz", buzzer, 0);
    start_key = 1'b0;
    repeat (3) @(negedge clk_in);
    press_start();
    chk("post_rst_state", state, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
